// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the MEM-stage data-memory controller: opcodes,
// funct3 access codes, FSM state encodings and the latched-op record.
package mem_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Copy of the access taken at detect time; the live inputs are not
    // trusted once the controller has left IDLE.
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } mem_op_t;

    function automatic logic is_mem_opcode(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_ctrl_lsu_align.sv
// Byte-lane alignment for the data-memory port: store byte enables and
// lane-replicated write data, load extraction/extension, and the
// illegal-or-misaligned flag.
module lsu_align
    import mem_ctrl_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic        bad
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
    assign rhalf = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Decode size/sign; unsigned variants only exist for loads.
    always_comb begin
        be       = 4'b0000;
        wdata    = 32'd0;
        load_val = 32'd0;
        bad      = 1'b0;
        case (funct3)
            F3_B: begin
                be       = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                load_val = {{24{rbyte[7]}}, rbyte};
            end
            F3_H: begin
                bad      = addr_lo[0];
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                load_val = {{16{rhalf[15]}}, rhalf};
            end
            F3_W: begin
                bad      = |addr_lo;
                be       = 4'b1111;
                wdata    = store_data;
                load_val = rdata;
            end
            F3_BU: begin
                bad      = is_store;
                load_val = {24'd0, rbyte};
            end
            F3_HU: begin
                bad      = is_store | addr_lo[0];
                load_val = {16'd0, rhalf};
            end
            default: bad = 1'b1;
        endcase
        if (!is_store) be = 4'b0000;
    end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage data-memory sequencer: detects a load/store, issues one
// req/ack transaction (or flags an error), stalls upstream until done.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_out_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    logic [1:0]       state;
    logic [TMO_W-1:0] cnt;
    mem_op_t          op_q;
    mem_op_t          op_sel;
    logic             mem_op;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_load;
    logic             al_bad;

    assign mem_op = valid_i & is_mem_opcode(opcode_i);

    // Align from live inputs while detecting, from the latched copy after.
    always_comb begin
        op_sel = op_q;
        if (state == ST_IDLE) begin
            op_sel.is_store = (opcode_i == OPC_STORE);
            op_sel.funct3   = funct3_i;
            op_sel.addr_lo  = addr_i[1:0];
        end
    end

    lsu_align u_align (
        .is_store   (op_sel.is_store),
        .addr_lo    (op_sel.addr_lo),
        .funct3     (op_sel.funct3),
        .store_data (store_data_i),
        .rdata      (dmem_rdata_i),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_val   (al_load),
        .bad        (al_bad)
    );

    // rst_n gate keeps stall low while held in reset even if valid_i is high.
    assign stall_o = rst_n & (((state == ST_IDLE) & mem_op) | (state == ST_REQ));
    assign done_o  = (state == ST_DONE);

    // Transaction FSM plus registered port and result state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_q         <= '0;
            err_o        <= 1'b0;
            load_out_o   <= 32'd0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        op_q <= op_sel;
                        if (al_bad) begin
                            state      <= ST_DONE;
                            err_o      <= 1'b1;
                            load_out_o <= 32'd0;
                        end else begin
                            state        <= ST_REQ;
                            cnt          <= '0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= op_sel.is_store;
                            dmem_addr_o  <= {addr_i[31:2], 2'b00};
                            dmem_be_o    <= al_be;
                            dmem_wdata_o <= al_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_ack_i) begin
                        state      <= ST_DONE;
                        dmem_req_o <= 1'b0;
                        err_o      <= 1'b0;
                        load_out_o <= op_q.is_store ? 32'd0 : al_load;
                    end else if (cnt == TMO_W'(TIMEOUT - 1)) begin
                        state      <= ST_DONE;
                        dmem_req_o <= 1'b0;
                        err_o      <= 1'b1;
                        load_out_o <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus random loads/stores
// checked against an arithmetic reference model of the access rules.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk, rst_n, valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] load_out_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    int n_chk = 0;
    int n_pass = 0;

    mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .load_out_o(load_out_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---- reference model ----
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int sz;
        longint v, lim;
        sz = m_size(f3);
        if (sz == 4) return rd;
        lim = longint'(1) << (8 * sz);
        v = (longint'(rd) >> (8 * (a % 4))) % lim;
        if (!f3[2] && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << m_size(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    // One complete access from detect to the cycle after DONE.
    // ack_at = REQ cycle (1-based) carrying the ack; 0 = never ack.
    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int ack_at, input logic [31:0] rd);
        bit st, bad, exp_err;
        int exp_req, req_cyc;
        logic [31:0] exp_lo;
        st      = (opc == OPC_STORE);
        bad     = m_bad(st, f3, a);
        exp_req = bad ? 0 : ((ack_at == 0) ? TIMEOUT : ack_at);
        exp_err = bad || (ack_at == 0);
        exp_lo  = (exp_err || st) ? 32'd0 : m_load(f3, a, rd);
        req_cyc = 0;

        valid_i = 1'b1; opcode_i = opc; funct3_i = f3; addr_i = a; store_data_i = sd;
        #1;
        chk({tag, ".stall_detect"}, stall_o, 1);
        chk({tag, ".req_detect"}, dmem_req_o, 0);
        @(posedge clk); #1;
        for (int c = 0; c < TIMEOUT + 4 && done_o !== 1'b1; c++) begin
            chk({tag, ".req"}, dmem_req_o, 1);
            chk({tag, ".stall_req"}, stall_o, 1);
            chk({tag, ".addr"}, dmem_addr_o, {a[31:2], 2'b00});
            if (c == 0) begin
                chk({tag, ".we"}, dmem_we_o, st);
                chk({tag, ".be"}, dmem_be_o, st ? m_be(f3, a) : 4'b0000);
                if (st) chk({tag, ".wdata"}, dmem_wdata_o, m_wdata(f3, sd));
            end
            funct3_i = 3'($urandom); addr_i = $urandom; store_data_i = $urandom;
            if (ack_at == c + 1) begin dmem_ack_i = 1'b1; dmem_rdata_i = rd; end
            @(posedge clk); #1;
            dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
            req_cyc++;
        end
        chk({tag, ".done"}, done_o, 1);
        chk({tag, ".req_cycles"}, req_cyc, exp_req);
        chk({tag, ".err"}, err_o, exp_err);
        chk({tag, ".load_out"}, load_out_o, exp_lo);
        chk({tag, ".stall_done"}, stall_o, 0);
        chk({tag, ".req_done"}, dmem_req_o, 0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done_o, 0);
        chk({tag, ".load_hold"}, load_out_o, exp_lo);
        chk({tag, ".err_hold"}, err_o, exp_err);
    endtask

    initial begin
        logic [6:0]  r_opc;
        logic [2:0]  r_f3;
        logic [31:0] r_a;

        rst_n = 1'b0; valid_i = 1'b1; opcode_i = OPC_LOAD; funct3_i = F3_W;
        addr_i = 32'h100; store_data_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", stall_o, 0);
        chk("rst.done", done_o, 0);
        chk("rst.err", err_o, 0);
        chk("rst.load_out", load_out_o, 0);
        chk("rst.req", dmem_req_o, 0);
        chk("rst.we", dmem_we_o, 0);
        chk("rst.addr", dmem_addr_o, 0);
        chk("rst.be", dmem_be_o, 0);
        chk("rst.wdata", dmem_wdata_o, 0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the access rules.
        run_op("lw",   OPC_LOAD,  F3_W,  32'h100, 32'h0,       2, 32'hDEADBEEF);
        run_op("lb",   OPC_LOAD,  F3_B,  32'h103, 32'h0,       1, 32'h80FFFF7F);
        run_op("lbu",  OPC_LOAD,  F3_BU, 32'h103, 32'h0,       1, 32'h80FFFF7F);
        run_op("lhu",  OPC_LOAD,  F3_HU, 32'h102, 32'h0,       3, 32'h80FFFF7F);
        run_op("lh",   OPC_LOAD,  F3_H,  32'h102, 32'h0,       1, 32'h80FFFF7F);
        run_op("sh",   OPC_STORE, F3_H,  32'h22,  32'h1234ABCD, 1, 32'h0);
        run_op("sb",   OPC_STORE, F3_B,  32'h41,  32'h000000A5, 2, 32'h0);
        run_op("sw",   OPC_STORE, F3_W,  32'h80,  32'hCAFEF00D, 1, 32'h0);
        run_op("lwmis", OPC_LOAD, F3_W,  32'h101, 32'h0,       1, 32'h12345678);
        run_op("sbill", OPC_STORE, 3'b011, 32'h40, 32'h55,     1, 32'h0);
        run_op("lhmis", OPC_LOAD, F3_HU, 32'h103, 32'h0,       1, 32'h0);
        run_op("tmo",  OPC_LOAD,  F3_W,  32'h200, 32'h0,       0, 32'h0);

        // Late ack after the timeout must not disturb anything.
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        chk("late_ack.done", done_o, 0);
        chk("late_ack.req", dmem_req_o, 0);
        chk("late_ack.err", err_o, 1);
        chk("late_ack.load_out", load_out_o, 0);

        // Reset while a request is outstanding.
        valid_i = 1'b1; opcode_i = OPC_LOAD; funct3_i = F3_W; addr_i = 32'h300;
        @(posedge clk); #1;
        chk("midrst.req_before", dmem_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.req", dmem_req_o, 0);
        chk("midrst.stall", stall_o, 0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h11111111;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        chk("midrst.ack_ignored_done", done_o, 0);
        chk("midrst.ack_ignored_load", load_out_o, 0);
        run_op("postrst", OPC_LOAD, F3_W, 32'h304, 32'h0, 1, 32'h0BADF00D);

        // Random accesses, biased toward legal sizes and alignments.
        for (int i = 0; i < 40; i++) begin
            r_opc = ($urandom_range(0, 1) == 1) ? OPC_STORE : OPC_LOAD;
            r_f3  = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            if ($urandom_range(0, 3) != 0) r_a[1:0] = (r_f3[1:0] == 2'd2) ? 2'd0 :
                                                      (r_f3[1:0] == 2'd1) ? {r_a[1], 1'b0} : r_a[1:0];
            run_op("rand", r_opc, r_f3, r_a, $urandom, $urandom_range(1, 4), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sequences the data-memory access for the instruction in the MEM stage.
- Drives a req/ack data-memory port and stalls the pipeline (IF..EX/MEM) until the access completes.
- Aligns store data and byte enables; extracts and sign/zero-extends load data.
- Sits between the EX/MEM register and the MEM/WB register: load_out_o feeds the MEM/WB load_out_i.

Parameters:
TIMEOUT, 16, max cycles in REQ without dmem_ack_i before abort (>=2)
TMO_W, $clog2(TIMEOUT)+1, timeout counter width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
valid_i  in  1  EX/MEM slot holds a live instruction
opcode_i  in  7  instruction opcode
funct3_i  in  3  access size/sign
addr_i  in  32  effective byte address (ALU result)
store_data_i  in  32  rs2 value
stall_o  out  1  hold upstream pipeline registers
done_o  out  1  1-cycle pulse: access finished, load_out_o/err_o valid
err_o  out  1  access failed (misaligned, illegal funct3, timeout); valid with done_o
load_out_o  out  32  extended load result
dmem_req_o  out  1  memory request, held until ack
dmem_we_o  out  1  1=store
dmem_addr_o  out  32  word address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables (stores; 4'b0000 for loads)
dmem_wdata_o  out  32  lane-replicated store data
dmem_ack_i  in  1  memory completion, 1 cycle
dmem_rdata_i  in  32  read word, valid with ack

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset: state IDLE. All outputs 0, including stall_o, done_o, err_o, load_out_o and every dmem_* output.
- Memory op = valid_i & (opcode_i==`opcode_load | opcode_i==`opcode_store).
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- State IDLE:
  - no memory op: stall_o=0, stay.
  - memory op: stall_o=1; latch op, funct3, addr, data.
    - legal and aligned -> REQ: register dmem_* outputs, req=1, counter=0.
    - illegal or misaligned -> DONE with err; no dmem request ever issued.
- State REQ:
  - stall_o=1; dmem_* held stable; counter increments each cycle.
  - dmem_ack_i=1 -> capture extracted rdata (loads) -> DONE; req drops the next cycle.
  - counter==TIMEOUT-1 without ack -> drop req -> DONE with err_o=1.
- State DONE:
  - done_o=1, stall_o=0 (pipeline advances this edge).
  - load_out_o valid: 0 for stores and on error.
  - err_o as set on entry.
  - next state IDLE unconditionally.
- Minimum latency: IDLE (detect) + REQ (ack same cycle) + DONE = 3 cycles; back-to-back ops repeat this with no overlap.
- load_out_o and err_o are held until the next DONE.
- Load extract:
  - LB/LBU: byte addr[1:0], sign/zero-extended.
  - LH/LHU: half addr[1], sign/zero-extended.
  - LW: whole word.
- Store:
  - SB: be=4'b0001<<addr[1:0], wdata={4{b}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{h}}.
  - SW: be=4'b1111.
- Ignore rules:
  - dmem_ack_i outside REQ is ignored.
  - Input changes during REQ/DONE are ignored (latched copy used).
- Reset mid-REQ: req drops immediately (async); the outstanding ack after reset is ignored.

Decomposition:
- Opcodes, funct3 codes and state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2) live in define.v.
- One combinational sub-module, lsu_align: inputs addr[1:0], funct3, store data, rdata; outputs be, wdata, extended load value, misaligned/illegal flag.

Test Plan:
- LW addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF -> dmem_addr_o=0x100, stall_o high 3 cycles, done_o pulse, load_out_o=0xDEADBEEF, err_o=0.
- LB addr 0x103 with rdata 0x80FF_FF7F -> load_out_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x22, data 0x1234ABCD -> dmem_be_o=4'b1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1, dmem_addr_o=0x20.
- LW addr 0x101 -> no dmem_req_o, DONE the cycle after detect, err_o=1, load_out_o=0; then SB funct3=011 -> same error path.
- No ack for TIMEOUT=16 cycles -> dmem_req_o drops after 16 REQ cycles, done_o with err_o=1; a late ack afterwards has no effect.
- rst_n low during REQ -> dmem_req_o and stall_o 0 immediately; after release a new LW completes normally.
